// File: rtl/upower_pkg.sv
// Shared opcode/xo constants, decode classes and the issue packet layout.
package upower_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [5:0] OP_ADDI  = 6'd14;
  localparam logic [5:0] OP_ADDIS = 6'd15;
  localparam logic [5:0] OP_B     = 6'd18;
  localparam logic [5:0] OP_XL    = 6'd19;
  localparam logic [5:0] OP_ORI   = 6'd24;
  localparam logic [5:0] OP_XORI  = 6'd26;
  localparam logic [5:0] OP_ANDI  = 6'd28;
  localparam logic [5:0] OP_X     = 6'd31;
  localparam logic [5:0] OP_LWZ   = 6'd32;
  localparam logic [5:0] OP_LBZ   = 6'd34;
  localparam logic [5:0] OP_STW   = 6'd36;
  localparam logic [5:0] OP_STWU  = 6'd37;
  localparam logic [5:0] OP_STB   = 6'd38;
  localparam logic [5:0] OP_LHZ   = 6'd40;
  localparam logic [5:0] OP_LHA   = 6'd42;
  localparam logic [5:0] OP_STH   = 6'd44;
  localparam logic [5:0] OP_LD    = 6'd58;
  localparam logic [5:0] OP_STD   = 6'd62;

  localparam logic [8:0] XO_ADD   = 9'd266;
  localparam logic [8:0] XO_SUBF  = 9'd40;
  localparam logic [9:0] X_AND    = 10'd28;
  localparam logic [9:0] X_OR     = 10'd444;
  localparam logic [9:0] X_XOR    = 10'd316;
  localparam logic [9:0] X_NAND   = 10'd476;
  localparam logic [9:0] X_EXTSW  = 10'd986;

  typedef enum logic [2:0] {
    ALU_XO, ALU_X, D_ARITH, D_LOGIC, LOAD, STORE, BR, ILLEGAL
  } dec_class_e;

  typedef struct packed {
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [XLEN-1:0] bo;
    logic [XLEN-1:0] bi;
    logic [5:0]      opcode;
    logic [8:0]      xoxo;
    logic [9:0]      xox;
    logic            rc;
    logic            aa;
    logic [13:0]     ds;
    logic [15:0]     si;
    logic [1:0]      xods;
    logic            dest_we;
    logic [4:0]      dest_addr;
  } issue_pkt_t;

endpackage

// File: rtl/upower_field_decode.sv
// Combinational instruction splitter: class, register routing and raw fields.
// Operand slots (rs/rt) of the returned packet are left 0; the top fills them.
module upower_field_decode
  import upower_pkg::*;
(
  input  logic [ILEN-1:0] i_instr,
  output dec_class_e      o_cls,
  output logic [4:0]      o_src_a,
  output logic [4:0]      o_src_b,
  output logic            o_use_a,
  output logic            o_use_b,
  output issue_pkt_t      o_pkt
);

  logic [5:0] w_op;
  logic [4:0] w_rt, w_ra, w_rb;
  logic [8:0] w_xoxo;
  logic [9:0] w_xox;

  assign w_op   = i_instr[31:26];
  assign w_rt   = i_instr[25:21];
  assign w_ra   = i_instr[20:16];
  assign w_rb   = i_instr[15:11];
  assign w_xoxo = i_instr[9:1];
  assign w_xox  = i_instr[10:1];

  // Classify the opcode and route source/dest indices; raw fields always pass
  always_comb begin
    o_cls     = ILLEGAL;
    o_src_a   = '0;
    o_src_b   = '0;
    o_use_a   = 1'b0;
    o_use_b   = 1'b0;
    o_pkt     = '0;
    o_pkt.opcode = w_op;
    o_pkt.bo     = {59'd0, w_rt};
    o_pkt.bi     = {59'd0, w_ra};
    o_pkt.rc     = i_instr[0];
    o_pkt.aa     = i_instr[1];
    o_pkt.ds     = i_instr[15:2];
    o_pkt.si     = i_instr[15:0];
    o_pkt.xods   = i_instr[1:0];
    case (w_op)
      OP_X: begin
        // XO match is checked first so an OE=1 add still decodes as XO-form
        if (w_xoxo == XO_ADD || w_xoxo == XO_SUBF) begin
          o_cls = ALU_XO;  o_pkt.xoxo = w_xoxo;
          o_src_a = w_ra;  o_use_a = 1'b1;
          o_src_b = w_rb;  o_use_b = 1'b1;
          o_pkt.dest_we = 1'b1;  o_pkt.dest_addr = w_rt;
        end else if (w_xox inside {X_AND, X_OR, X_XOR, X_NAND, X_EXTSW}) begin
          o_cls = ALU_X;   o_pkt.xox = w_xox;
          o_src_a = w_rt;  o_use_a = 1'b1;
          o_src_b = w_rb;  o_use_b = 1'b1;
          o_pkt.dest_we = 1'b1;  o_pkt.dest_addr = w_ra;
        end
      end
      OP_ADDI, OP_ADDIS: begin
        // RA=0 means literal zero, so r0 is neither read nor hazard-checked
        o_cls = D_ARITH;  o_src_a = w_ra;  o_use_a = (w_ra != 5'd0);
        o_pkt.dest_we = 1'b1;  o_pkt.dest_addr = w_rt;
      end
      OP_ORI, OP_XORI, OP_ANDI: begin
        o_cls = D_LOGIC;  o_src_a = w_rt;  o_use_a = 1'b1;
        o_pkt.dest_we = 1'b1;  o_pkt.dest_addr = w_ra;
      end
      OP_LWZ, OP_LBZ, OP_LHZ, OP_LHA, OP_LD: begin
        o_cls = LOAD;  o_src_a = w_ra;  o_use_a = (w_ra != 5'd0);
        o_pkt.dest_we = 1'b1;  o_pkt.dest_addr = w_rt;
      end
      OP_STW, OP_STWU, OP_STB, OP_STH, OP_STD: begin
        o_cls = STORE;
        o_src_a = w_ra;  o_use_a = 1'b1;
        o_src_b = w_rt;  o_use_b = 1'b1;
      end
      OP_B: o_cls = BR;
      OP_XL: begin
        o_cls = BR;
        o_src_a = w_rt;  o_use_a = 1'b1;
        o_src_b = w_ra;  o_use_b = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/upower_decode_issue.sv
// Two-stage decode/issue front end with register scoreboard, backpressure and flush.
module upower_decode_issue
  import upower_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_instr_valid,
  output logic            o_instr_ready,
  input  logic [ILEN-1:0] i_instr,
  input  logic            i_flush,
  output logic [4:0]      o_rf_addr_a,
  output logic [4:0]      o_rf_addr_b,
  input  logic [XLEN-1:0] i_rf_data_a,
  input  logic [XLEN-1:0] i_rf_data_b,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_addr,
  output logic            o_issue_valid,
  input  logic            i_issue_ready,
  output logic [XLEN-1:0] o_rs,
  output logic [XLEN-1:0] o_rt,
  output logic [XLEN-1:0] o_bo,
  output logic [XLEN-1:0] o_bi,
  output logic [5:0]      o_opcode,
  output logic [8:0]      o_xoxo,
  output logic [9:0]      o_xox,
  output logic            o_rc,
  output logic            o_aa,
  output logic [13:0]     o_ds,
  output logic [15:0]     o_si,
  output logic [1:0]      o_xods,
  output logic            o_dest_we,
  output logic [4:0]      o_dest_addr,
  output logic            o_illegal
);

  // [0] = decode register valid, [1] = issue register valid
  logic [1:0]      r_vld_pipe;
  logic [ILEN-1:0] r_dec_instr;
  issue_pkt_t      r_iss;
  logic [31:0]     r_busy;

  dec_class_e  w_cls;
  logic [4:0]  w_src_a, w_src_b;
  logic        w_use_a, w_use_b;
  issue_pkt_t  w_pkt, w_iss_pkt;
  logic [31:0] w_wb_clr, w_busy_eff, w_set;
  logic        w_illegal, w_hazard, w_iss_free, w_dec_adv, w_dec_leave;

  upower_field_decode u_dec (
    .i_instr (r_dec_instr),
    .o_cls   (w_cls),
    .o_src_a (w_src_a),
    .o_src_b (w_src_b),
    .o_use_a (w_use_a),
    .o_use_b (w_use_b),
    .o_pkt   (w_pkt)
  );

  // A same-cycle writeback already frees its register for the hazard check
  assign w_wb_clr   = i_wb_valid ? (32'd1 << i_wb_addr) : 32'd0;
  assign w_busy_eff = r_busy & ~w_wb_clr;
  assign w_illegal  = r_vld_pipe[0] && (w_cls == ILLEGAL);
  assign w_hazard   = (w_use_a && w_busy_eff[w_src_a]) || (w_use_b && w_busy_eff[w_src_b]);
  assign w_iss_free = !r_vld_pipe[1] || i_issue_ready;
  assign w_dec_adv  = r_vld_pipe[0] && !w_illegal && !w_hazard && w_iss_free;
  // Illegal words drop out of decode unconditionally
  assign w_dec_leave = w_dec_adv || w_illegal;
  assign w_set       = (w_dec_adv && w_pkt.dest_we) ? (32'd1 << w_pkt.dest_addr) : 32'd0;

  assign o_instr_ready = !r_vld_pipe[0] || w_dec_leave;
  assign o_illegal     = w_illegal;
  assign o_rf_addr_a   = r_vld_pipe[0] ? w_src_a : 5'd0;
  assign o_rf_addr_b   = r_vld_pipe[0] ? w_src_b : 5'd0;

  // Attach register-file operands; unused slots are forced to zero
  always_comb begin
    w_iss_pkt    = w_pkt;
    w_iss_pkt.rs = w_use_a ? i_rf_data_a : '0;
    w_iss_pkt.rt = w_use_b ? i_rf_data_b : '0;
  end

  // Decode and issue registers with handshake; flush kills both stages
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld_pipe  <= '0;
      r_dec_instr <= '0;
      r_iss       <= '0;
    end else if (i_flush) begin
      r_vld_pipe  <= '0;
    end else begin
      if (i_instr_valid && o_instr_ready) begin
        r_vld_pipe[0] <= 1'b1;
        r_dec_instr   <= i_instr;
      end else if (w_dec_leave) begin
        r_vld_pipe[0] <= 1'b0;
      end
      if (w_dec_adv) begin
        r_vld_pipe[1] <= 1'b1;
        r_iss         <= w_iss_pkt;
      end else if (i_issue_ready) begin
        r_vld_pipe[1] <= 1'b0;
      end
    end
  end

  // Scoreboard: writebacks clear, issue sets; set wins on the same register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_busy <= '0;
    else         r_busy <= (r_busy & ~w_wb_clr) | (i_flush ? 32'd0 : w_set);
  end

  assign o_issue_valid = r_vld_pipe[1];
  assign o_rs          = r_iss.rs;
  assign o_rt          = r_iss.rt;
  assign o_bo          = r_iss.bo;
  assign o_bi          = r_iss.bi;
  assign o_opcode      = r_iss.opcode;
  assign o_xoxo        = r_iss.xoxo;
  assign o_xox         = r_iss.xox;
  assign o_rc          = r_iss.rc;
  assign o_aa          = r_iss.aa;
  assign o_ds          = r_iss.ds;
  assign o_si          = r_iss.si;
  assign o_xods        = r_iss.xods;
  assign o_dest_we     = r_iss.dest_we;
  assign o_dest_addr   = r_iss.dest_addr;

endmodule

// File: tb/tb_upower_decode_issue.sv
// Directed bench for the uPower decode/issue front end.
module tb_upower_decode_issue;

  logic        clk = 1'b0;
  logic        reset, instr_valid, flush, wb_valid, issue_ready;
  logic [31:0] instr;
  logic [4:0]  wb_addr, rf_addr_a, rf_addr_b, dest_addr;
  logic [63:0] rf_data_a, rf_data_b, rs, rt, bo, bi;
  logic        instr_ready, issue_valid, rc, aa, dest_we, illegal;
  logic [5:0]  opcode;
  logic [8:0]  xoxo;
  logic [9:0]  xox;
  logic [13:0] ds;
  logic [15:0] si;
  logic [1:0]  xods;
  logic [63:0] regs [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];

  upower_decode_issue dut (
    .i_clk(clk), .i_reset(reset), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_instr(instr), .i_flush(flush), .o_rf_addr_a(rf_addr_a), .o_rf_addr_b(rf_addr_b),
    .i_rf_data_a(rf_data_a), .i_rf_data_b(rf_data_b), .i_wb_valid(wb_valid), .i_wb_addr(wb_addr),
    .o_issue_valid(issue_valid), .i_issue_ready(issue_ready), .o_rs(rs), .o_rt(rt), .o_bo(bo),
    .o_bi(bi), .o_opcode(opcode), .o_xoxo(xoxo), .o_xox(xox), .o_rc(rc), .o_aa(aa), .o_ds(ds),
    .o_si(si), .o_xods(xods), .o_dest_we(dest_we), .o_dest_addr(dest_addr), .o_illegal(illegal)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready got %b exp 1", instr_ready); end
    checks++; if ({rs, rt, opcode, si, dest_we, dest_addr, illegal} !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {rs, rt, opcode, si, dest_we, dest_addr, illegal}); end
    checks++; if (dut.r_busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", dut.r_busy); end
  endtask

  // add r3,r4,r4 with r4=5
  task automatic test_add();
    instr = 32'h7C642214; instr_valid = 1'b1; tick(); instr_valid = 1'b0; #1;
    checks++; if ({rf_addr_a, rf_addr_b} !== {5'd4, 5'd4}) begin errors++; $display("FAIL add_rf_addr got %h exp %h", {rf_addr_a, rf_addr_b}, {5'd4, 5'd4}); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL add_early_issue got %b exp 0", issue_valid); end
    tick();
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL add_issue_valid got %b exp 1", issue_valid); end
    checks++; if ({opcode, xoxo, xox} !== {6'd31, 9'd266, 10'd0}) begin errors++; $display("FAIL add_op_xo got %h exp %h", {opcode, xoxo, xox}, {6'd31, 9'd266, 10'd0}); end
    checks++; if ({rs, rt} !== {64'd5, 64'd5}) begin errors++; $display("FAIL add_operands got %h exp %h", {rs, rt}, {64'd5, 64'd5}); end
    checks++; if ({dest_we, dest_addr, bo, bi} !== {1'b1, 5'd3, 64'd3, 64'd4}) begin errors++; $display("FAIL add_dest got %h exp %h", {dest_we, dest_addr, bo, bi}, {1'b1, 5'd3, 64'd3, 64'd4}); end
    checks++; if (dut.r_busy !== 32'h8) begin errors++; $display("FAIL add_busy got %h exp 8", dut.r_busy); end
  endtask

  // addi r5,r3,1 stalls on r3 until its writeback
  task automatic test_raw();
    regs[3] = 64'd42;
    instr = 32'h38A30001; instr_valid = 1'b1; tick(); instr_valid = 1'b0; #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_ready got %b exp 0", instr_ready); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL raw_no_issue cycle %0d got %b exp 0", k, issue_valid); end
      tick();
    end
    wb_valid = 1'b1; wb_addr = 5'd3; #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %b exp 1", instr_ready); end
    tick(); wb_valid = 1'b0;
    checks++; if ({issue_valid, opcode, si, dest_addr} !== {1'b1, 6'd14, 16'd1, 5'd5}) begin errors++; $display("FAIL raw_issue got %h exp %h", {issue_valid, opcode, si, dest_addr}, {1'b1, 6'd14, 16'd1, 5'd5}); end
    checks++; if ({rs, rt} !== {64'd42, 64'd0}) begin errors++; $display("FAIL raw_operands got %h exp %h", {rs, rt}, {64'd42, 64'd0}); end
    checks++; if (dut.r_busy !== 32'h20) begin errors++; $display("FAIL raw_busy got %h exp 20", dut.r_busy); end
    tick();
    wb_valid = 1'b1; wb_addr = 5'd5; tick(); wb_valid = 1'b0;
    checks++; if ({issue_valid, dut.r_busy} !== 33'd0) begin errors++; $display("FAIL raw_drain got %h exp 0", {issue_valid, dut.r_busy}); end
  endtask

  // Three branches with the execute stage stalled
  task automatic test_backpressure();
    issue_ready = 1'b0;
    instr = 32'h48000010; instr_valid = 1'b1; tick();
    instr = 32'h48000020; tick();
    instr = 32'h48000030; #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({issue_valid, si} !== {1'b1, 16'h0010}) begin errors++; $display("FAIL bp_hold cycle %0d got %h exp %h", k, {issue_valid, si}, {1'b1, 16'h0010}); end
      checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %b exp 0", k, instr_ready); end
      tick();
    end
    issue_ready = 1'b1; #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", instr_ready); end
    tick(); instr_valid = 1'b0;
    checks++; if ({issue_valid, si} !== {1'b1, 16'h0020}) begin errors++; $display("FAIL bp_second got %h exp %h", {issue_valid, si}, {1'b1, 16'h0020}); end
    tick();
    checks++; if ({issue_valid, si} !== {1'b1, 16'h0030}) begin errors++; $display("FAIL bp_third got %h exp %h", {issue_valid, si}, {1'b1, 16'h0030}); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", issue_valid); end
  endtask

  // opcode 0, then op31 with xo 999
  task automatic test_illegal();
    instr = 32'h00000000; instr_valid = 1'b1; tick(); instr_valid = 1'b0; #1;
    checks++; if ({illegal, instr_ready} !== 2'b11) begin errors++; $display("FAIL ill_op0_pulse got %b exp 11", {illegal, instr_ready}); end
    tick();
    checks++; if ({illegal, issue_valid} !== 2'b00) begin errors++; $display("FAIL ill_op0_after got %b exp 00", {illegal, issue_valid}); end
    instr = 32'h7C0007CE; instr_valid = 1'b1; tick(); instr_valid = 1'b0; #1;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_xo999_pulse got %b exp 1", illegal); end
    tick();
    checks++; if ({illegal, issue_valid, dut.r_busy} !== 34'd0) begin errors++; $display("FAIL ill_xo999_after got %h exp 0", {illegal, issue_valid, dut.r_busy}); end
  endtask

  // addi r10,r0,7 in issue, addi r11,r0,8 in decode, then flush
  task automatic test_flush();
    issue_ready = 1'b0;
    instr = 32'h39400007; instr_valid = 1'b1; tick();
    instr = 32'h39600008; tick();
    checks++; if ({issue_valid, dest_addr, si, rs} !== {1'b1, 5'd10, 16'd7, 64'd0}) begin errors++; $display("FAIL flush_pre got %h exp %h", {issue_valid, dest_addr, si, rs}, {1'b1, 5'd10, 16'd7, 64'd0}); end
    flush = 1'b1; issue_ready = 1'b1; instr = 32'h39800009; tick();
    flush = 1'b0; instr_valid = 1'b0; #1;
    checks++; if ({issue_valid, dut.r_busy} !== {1'b0, 32'h400}) begin errors++; $display("FAIL flush_next got %h exp %h", {issue_valid, dut.r_busy}, {1'b0, 32'h400}); end
    tick();
    checks++; if ({issue_valid, dut.r_busy} !== {1'b0, 32'h400}) begin errors++; $display("FAIL flush_discard got %h exp %h", {issue_valid, dut.r_busy}, {1'b0, 32'h400}); end
    wb_valid = 1'b1; wb_addr = 5'd10; tick(); wb_valid = 1'b0;
    checks++; if (dut.r_busy !== 32'h0) begin errors++; $display("FAIL flush_wb got %h exp 0", dut.r_busy); end
  endtask

  task automatic test_reset_mid();
    issue_ready = 1'b0;
    instr = 32'h39400007; instr_valid = 1'b1; tick();
    instr = 32'h39600008; tick(); instr_valid = 1'b0;
    checks++; if ({issue_valid, dut.r_busy} !== {1'b1, 32'h400}) begin errors++; $display("FAIL rmid_pre got %h exp %h", {issue_valid, dut.r_busy}, {1'b1, 32'h400}); end
    reset = 1'b1; tick(); reset = 1'b0; #1;
    checks++; if ({issue_valid, rs, rt, bo, bi, opcode, xoxo, xox, rc, aa, ds, si, xods, dest_we, dest_addr, illegal} !== '0) begin errors++; $display("FAIL rmid_outputs got %h exp 0", {issue_valid, rs, rt, bo, bi, opcode, xoxo, xox, rc, aa, ds, si, xods, dest_we, dest_addr, illegal}); end
    checks++; if ({dut.r_busy, rf_addr_a, rf_addr_b} !== 42'd0) begin errors++; $display("FAIL rmid_state got %h exp 0", {dut.r_busy, rf_addr_a, rf_addr_b}); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", instr_ready); end
    issue_ready = 1'b1;
  endtask

  // and r7,r8,r9 ; stw r8,4(r9) ; ld r6,8(r9) issued one per cycle
  task automatic test_back_to_back();
    regs[8] = 64'h1111; regs[9] = 64'h2222;
    instr = 32'h7D074838; instr_valid = 1'b1; tick();
    instr = 32'h91090004; tick();
    checks++; if ({issue_valid, opcode, xoxo, xox} !== {1'b1, 6'd31, 9'd0, 10'd28}) begin errors++; $display("FAIL b2b_and_op got %h exp %h", {issue_valid, opcode, xoxo, xox}, {1'b1, 6'd31, 9'd0, 10'd28}); end
    checks++; if ({rs, rt, dest_we, dest_addr, bo, bi} !== {64'h1111, 64'h2222, 1'b1, 5'd7, 64'd8, 64'd7}) begin errors++; $display("FAIL b2b_and_data got %h exp %h", {rs, rt, dest_we, dest_addr, bo, bi}, {64'h1111, 64'h2222, 1'b1, 5'd7, 64'd8, 64'd7}); end
    instr = 32'hE8C90008; tick(); instr_valid = 1'b0;
    checks++; if ({issue_valid, opcode, dest_we, rs, rt} !== {1'b1, 6'd36, 1'b0, 64'h2222, 64'h1111}) begin errors++; $display("FAIL b2b_store got %h exp %h", {issue_valid, opcode, dest_we, rs, rt}, {1'b1, 6'd36, 1'b0, 64'h2222, 64'h1111}); end
    wb_valid = 1'b1; wb_addr = 5'd6; tick(); wb_valid = 1'b0;
    checks++; if ({issue_valid, opcode, ds, xods, dest_addr, rs, rt} !== {1'b1, 6'd58, 14'd2, 2'd0, 5'd6, 64'h2222, 64'd0}) begin errors++; $display("FAIL b2b_load got %h exp %h", {issue_valid, opcode, ds, xods, dest_addr, rs, rt}, {1'b1, 6'd58, 14'd2, 2'd0, 5'd6, 64'h2222, 64'd0}); end
    checks++; if (dut.r_busy !== 32'hC0) begin errors++; $display("FAIL b2b_set_wins got %h exp c0", dut.r_busy); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", issue_valid); end
    wb_valid = 1'b1; wb_addr = 5'd7; tick(); wb_addr = 5'd6; tick(); wb_valid = 1'b0;
    checks++; if (dut.r_busy !== 32'h0) begin errors++; $display("FAIL b2b_wb got %h exp 0", dut.r_busy); end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_addr = '0;
    issue_ready = 1'b1; instr = '0;
    for (int i = 0; i < 32; i++) regs[i] = 64'hA000 + 64'(i);
    regs[0] = 64'd99;
    regs[4] = 64'd5;
    test_reset();
    test_add();
    test_raw();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
